// File: rtl/button_pio_ctrl.sv
// Button PIO service controller: programs the PIO irq_mask, reads and clears edge_capture
// on interrupt, hands out one event per set bit, then locks out bounce for HOLDOFF_CYCLES.
module button_pio_ctrl #(
  parameter int unsigned HOLDOFF_CYCLES = 1000,
  parameter logic [3:0]  MASK_INIT      = 4'hF
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        pio_irq,
  output logic        evt_valid,
  output logic [1:0]  evt_code,
  input  logic        evt_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StRead,
    StWaitRd,
    StClear,
    StDispatch,
    StHoldoff,
    StDiscard
  } state_e;

  localparam logic [1:0]  AddrMask = 2'd2;
  localparam logic [1:0]  AddrEdge = 2'd3;
  localparam logic [15:0] HoldLoad = 16'(HOLDOFF_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic [15:0] cnt_q, cnt_d;
  logic        started_q, started_d;

  logic [1:0]  addr_q, addr_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic [1:0]  code_q, code_d;
  logic        busy_q, busy_d;

  logic        unused_rd;
  assign unused_rd = ^avm_readdata[31:4];

  function automatic logic [1:0] lowest_bit(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Next state and pending/counter updates.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    started_d = 1'b1;
    unique case (state_q)
      StInit:     if (started_q) state_d = StIdle;
      StIdle:     if (pio_irq) state_d = StRead;
      StRead:     state_d = StWaitRd;
      StWaitRd: begin
        pending_d = avm_readdata[3:0];
        state_d   = StClear;
      end
      StClear:    state_d = StDispatch;
      StDispatch: begin
        if (pending_q == 4'd0) begin
          cnt_d   = HoldLoad;
          state_d = StHoldoff;
        end else if (evt_ready) begin
          pending_d = pending_q & ~(4'b0001 << lowest_bit(pending_q));
        end
      end
      StHoldoff: begin
        if (cnt_q == 16'd0) state_d = StDiscard;
        else                cnt_d   = cnt_q - 16'd1;
      end
      StDiscard:  state_d = StIdle;
      default:    state_d = StInit;
    endcase
  end

  // Outputs are registered from the state being entered so they line up with state_q.
  always_comb begin
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = 2'd0;
    wdata_d = 32'd0;
    valid_d = 1'b0;
    code_d  = 2'd0;
    busy_d  = (state_d != StIdle);
    unique case (state_d)
      StInit: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = AddrMask;
        wdata_d = {28'd0, MASK_INIT};
      end
      StRead: begin
        cs_d   = 1'b1;
        addr_d = AddrEdge;
      end
      StWaitRd:   addr_d = AddrEdge;
      StClear, StDiscard: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = AddrEdge;
      end
      StDispatch: begin
        valid_d = (pending_d != 4'd0);
        code_d  = (pending_d != 4'd0) ? lowest_bit(pending_d) : 2'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StInit;
      pending_q <= 4'd0;
      cnt_q     <= 16'd0;
      started_q <= 1'b0;
      addr_q    <= 2'd0;
      cs_q      <= 1'b0;
      wn_q      <= 1'b1;
      wdata_q   <= 32'd0;
      valid_q   <= 1'b0;
      code_q    <= 2'd0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
      wn_q      <= wn_d;
      wdata_q   <= wdata_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = wdata_q;
  assign evt_valid      = valid_q;
  assign evt_code       = code_q;
  assign busy           = busy_q;

endmodule
